// File: rtl/note_player_pkg.sv
`default_nettype none
// ============================================================================
// Module   : note_player_pkg
// Brief    : Shared widths, state encoding and the equal-tempered pitch table
//            used by the note player and its frequency ROM.
// Revision : 1.0 - initial release
// ============================================================================
package note_player_pkg;

    localparam int NOTE_W = 6;
    localparam int DUR_W  = 6;
    localparam int META_W = 3;
    localparam int STEP_W = 20;

    typedef enum logic [1:0] {
        NP_IDLE    = 2'd0,
        NP_LOAD    = 2'd1,
        NP_PLAYING = 2'd2,
        NP_DONE    = 2'd3
    } np_state_t;

    // Phase increments (20-bit accumulator, 48 kHz sample rate) for the
    // octave A5..G#6; lower octaves are derived by right-shifting.
    function automatic logic [STEP_W-1:0] top_octave_step(input logic [NOTE_W-1:0] semi);
        case (semi)
            6'd0:    return 20'd19224;
            6'd1:    return 20'd20367;
            6'd2:    return 20'd21578;
            6'd3:    return 20'd22861;
            6'd4:    return 20'd24221;
            6'd5:    return 20'd25661;
            6'd6:    return 20'd27187;
            6'd7:    return 20'd28804;
            6'd8:    return 20'd30516;
            6'd9:    return 20'd32331;
            6'd10:   return 20'd34253;
            6'd11:   return 20'd36290;
            default: return '0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/dffr.sv
`default_nettype none
// ============================================================================
// Module   : dffr
// Brief    : D flop bank with asynchronous active-low clear.
// Revision : 1.0 - initial release
// ============================================================================
module dffr #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    // Capture every cycle, clear asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) o_q <= '0;
        else        o_q <= i_d;
    end

endmodule
`default_nettype wire

// File: rtl/dffre.sv
`default_nettype none
// ============================================================================
// Module   : dffre
// Brief    : D flop bank with enable and asynchronous active-low clear.
// Revision : 1.0 - initial release
// ============================================================================
module dffre #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    // Capture only when enabled, clear asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)    o_q <= '0;
        else if (i_en) o_q <= i_d;
    end

endmodule
`default_nettype wire

// File: rtl/frequency_rom.sv
`default_nettype none
// ============================================================================
// Module   : frequency_rom
// Brief    : 64 x 20 synchronous pitch ROM. Note n (1..63) is n-1 semitones
//            above A0 (note 49 = A4 = 440 Hz); entry 0 is silence.
// Revision : 1.0 - initial release
// ============================================================================
module frequency_rom
    import note_player_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [NOTE_W-1:0] i_addr,
    output logic [STEP_W-1:0] o_data
);

    logic [NOTE_W-1:0] w_rel;
    logic [NOTE_W-1:0] w_semi;
    logic [NOTE_W-1:0] w_oct;
    logic [NOTE_W-1:0] w_shift;
    logic [STEP_W-1:0] w_data;

    // Split the note into semitone-within-octave and octave, then scale the
    // top-octave increment down by one bit per octave below it.
    always_comb begin
        w_rel   = i_addr - NOTE_W'(1);
        w_semi  = w_rel % NOTE_W'(12);
        w_oct   = w_rel / NOTE_W'(12);
        w_shift = NOTE_W'(5) - w_oct;
        w_data  = '0;
        if (i_addr != '0) begin
            w_data = top_octave_step(w_semi) >> w_shift;
        end
    end

    dffr #(.WIDTH(STEP_W)) u_data_q (
        .clk   (clk),
        .reset (reset),
        .i_d   (w_data),
        .o_q   (o_data)
    );

endmodule
`default_nettype wire

// File: rtl/note_player.sv
`default_nettype none
// ============================================================================
// Module   : note_player
// Brief    : Latches notes from the song reader, looks up the phase increment,
//            counts the note length in beats, silences the trailing gap beats
//            and pulses note_done when the note expires.
// Revision : 1.0 - initial release
// ============================================================================
module note_player
    import note_player_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              play,
    input  logic              new_note,
    input  logic [NOTE_W-1:0] note,
    input  logic [DUR_W-1:0]  duration,
    input  logic [META_W-1:0] metadata,
    input  logic              beat,
    output logic [STEP_W-1:0] step_size,
    output logic              active,
    output logic              note_done
);

    logic [1:0]        r_state;
    np_state_t         w_next_state;
    logic [NOTE_W-1:0] r_note_q;
    logic [DUR_W-1:0]  r_beats_left;
    logic [META_W-1:0] r_gap_q;
    logic [STEP_W-1:0] r_step_q;

    logic              w_beat_take;
    logic              w_beats_en;
    logic [DUR_W-1:0]  w_beats_d;
    logic              w_done_d;

    // A beat only counts while playing and unpaused; a new note wins over it.
    always_comb begin
        w_beat_take = (r_state == NP_PLAYING) && beat && play && !new_note;
        w_beats_en  = new_note || w_beat_take;
        w_beats_d   = new_note ? duration : (r_beats_left - DUR_W'(1));
        w_done_d    = (w_next_state == NP_DONE);
    end

    // Next-state logic; a new note restarts from any state.
    always_comb begin
        w_next_state = np_state_t'(r_state);
        if (new_note) begin
            w_next_state = NP_LOAD;
        end else begin
            case (r_state)
                NP_IDLE:    w_next_state = NP_IDLE;
                NP_LOAD:    w_next_state = (r_beats_left == '0) ? NP_DONE : NP_PLAYING;
                NP_PLAYING: begin
                    if (w_beat_take && (r_beats_left == DUR_W'(1))) begin
                        w_next_state = NP_DONE;
                    end
                end
                NP_DONE:    w_next_state = NP_IDLE;
                default:    w_next_state = NP_IDLE;
            endcase
        end
    end

    // Audible only while playing, unpaused, pitched and outside the gap.
    always_comb begin
        step_size = '0;
        if ((r_state == NP_PLAYING) && play && (r_note_q != '0) &&
            (r_beats_left > {{(DUR_W-META_W){1'b0}}, r_gap_q})) begin
            step_size = r_step_q;
        end
        active = (r_state == NP_LOAD) || (r_state == NP_PLAYING);
    end

    dffr #(.WIDTH(2)) u_state_q (
        .clk   (clk),
        .reset (reset),
        .i_d   (w_next_state),
        .o_q   (r_state)
    );

    dffre #(.WIDTH(NOTE_W)) u_note_q (
        .clk   (clk),
        .reset (reset),
        .i_en  (new_note),
        .i_d   (note),
        .o_q   (r_note_q)
    );

    dffre #(.WIDTH(META_W)) u_gap_q (
        .clk   (clk),
        .reset (reset),
        .i_en  (new_note),
        .i_d   (metadata),
        .o_q   (r_gap_q)
    );

    dffre #(.WIDTH(DUR_W)) u_beats_left (
        .clk   (clk),
        .reset (reset),
        .i_en  (w_beats_en),
        .i_d   (w_beats_d),
        .o_q   (r_beats_left)
    );

    // Registered so note_done is high exactly while the FSM sits in DONE.
    dffr #(.WIDTH(1)) u_note_done (
        .clk   (clk),
        .reset (reset),
        .i_d   (w_done_d),
        .o_q   (note_done)
    );

    frequency_rom u_rom (
        .clk    (clk),
        .reset  (reset),
        .i_addr (r_note_q),
        .o_data (r_step_q)
    );

endmodule
`default_nettype wire
